// File: rtl/fir_coeff_loader_if.sv
// Bus-bridge side of the FIR coefficient loader:
// load command and coefficient stream handshakes.
interface fir_coeff_loader_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_axis;
  logic [1:0]  cmd_bank;
  logic        cmd_activate;
  logic        coef_valid;
  logic        coef_ready;
  logic [15:0] coef_data;

  modport master (
    output cmd_valid,
    output cmd_axis,
    output cmd_bank,
    output cmd_activate,
    output coef_valid,
    output coef_data,
    input  cmd_ready,
    input  coef_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_axis,
    input  cmd_bank,
    input  cmd_activate,
    input  coef_valid,
    input  coef_data,
    output cmd_ready,
    output coef_ready
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// Streams one bank of FIR taps into the signal path and
// optionally flips that axis's active bank when it is idle.
module fir_coeff_loader #(
  parameter int         TAPS           = 16,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [1:0] RESET_BANK     = 2'd0
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  fir_coeff_loader_if.slave       bus,
  input  logic                    path_available,
  output logic                    update_en,
  output logic [1:0]              update_axis,
  output logic [1:0]              update_bank,
  output logic [$clog2(TAPS)-1:0] update_index,
  output logic [15:0]             update_value,
  output logic [1:0]              x_bank,
  output logic [1:0]              y_bank,
  output logic [1:0]              z_bank,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);
  localparam int IW = $clog2(TAPS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX =
    IW'(TAPS - 1);
  localparam logic [TW-1:0] TO_LIMIT =
    TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_SAFE,
    SWITCH,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [1:0]    axis_q;
  logic [1:0]    bank_q;
  logic          act_q;
  logic [IW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_inc;
  logic [1:0]    cur_bank;
  logic          cmd_fire;
  logic          reject;
  logic          beat;
  logic          abort;
  logic          sw;

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.coef_ready = (state == LOAD);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign tcnt_inc       = tcnt + TW'(1);

  always_comb begin
    cur_bank = RESET_BANK;
    unique case (1'b1)
      (bus.cmd_axis == 2'd1): cur_bank = x_bank;
      (bus.cmd_axis == 2'd2): cur_bank = y_bank;
      (bus.cmd_axis == 2'd3): cur_bank = z_bank;
      default:                cur_bank = RESET_BANK;
    endcase
  end

  always_comb begin
    state_n  = state;
    cmd_fire = 1'b0;
    reject   = 1'b0;
    beat     = 1'b0;
    abort    = 1'b0;
    sw       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_fire = 1'b1;
          // Loading the live bank would glitch filtering.
          if (bus.cmd_axis == 2'd0 ||
              bus.cmd_bank == cur_bank)
            reject = 1'b1;
          else
            state_n = LOAD;
        end
      end
      LOAD: begin
        if (bus.coef_valid) begin
          beat = 1'b1;
          if (idx == LAST_IDX)
            state_n = act_q ? WAIT_SAFE : DONE;
        end else if (tcnt_inc == TO_LIMIT) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_SAFE: begin
        if (path_available)
          state_n = SWITCH;
      end
      SWITCH: begin
        sw      = 1'b1;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      axis_q       <= 2'd0;
      bank_q       <= 2'd0;
      act_q        <= 1'b0;
      idx          <= '0;
      tcnt         <= '0;
      update_en    <= 1'b0;
      update_axis  <= 2'd0;
      update_bank  <= 2'd0;
      update_index <= '0;
      update_value <= 16'd0;
      x_bank       <= RESET_BANK;
      y_bank       <= RESET_BANK;
      z_bank       <= RESET_BANK;
      error        <= 1'b0;
    end else begin
      update_en <= beat;
      error     <= reject | abort;
      if (cmd_fire) begin
        axis_q <= bus.cmd_axis;
        bank_q <= bus.cmd_bank;
        act_q  <= bus.cmd_activate;
        idx    <= '0;
        tcnt   <= '0;
      end
      if (beat) begin
        update_axis  <= axis_q;
        update_bank  <= bank_q;
        update_index <= idx;
        update_value <= bus.coef_data;
        idx          <= idx + IW'(1);
        tcnt         <= '0;
      end else if (state == LOAD) begin
        tcnt <= tcnt_inc;
      end
      if (sw) begin
        case (axis_q)
          2'd1:    x_bank <= bank_q;
          2'd2:    y_bank <= bank_q;
          2'd3:    z_bank <= bank_q;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: directed loads,
// rejects, timeout, mid-load reset and gapped streaming.
module tb_fir_coeff_loader;
  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        path_available;
  logic        update_en;
  logic [1:0]  update_axis;
  logic [1:0]  update_bank;
  logic [3:0]  update_index;
  logic [15:0] update_value;
  logic [1:0]  x_bank, y_bank, z_bank;
  logic        busy, done, error;

  fir_coeff_loader_if bus ();

  fir_coeff_loader #(
    .TAPS(16),
    .TIMEOUT_CYCLES(20),
    .RESET_BANK(2'd0)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .bus(bus),
    .path_available(path_available),
    .update_en(update_en),
    .update_axis(update_axis),
    .update_bank(update_bank),
    .update_index(update_index),
    .update_value(update_value),
    .x_bank(x_bank),
    .y_bank(y_bank),
    .z_bank(z_bank),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 sys_clk = ~sys_clk;

  typedef enum int {
    S_XB, S_YB, S_ZB, S_BUSY, S_DONE, S_ERR,
    S_CMDR, S_COEFR, S_UEN, S_UAX, S_UBK,
    S_UIDX, S_UVAL
  } sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [15:0] val;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [1:0]  ax;
    logic [1:0]  bk;
    logic [3:0]  ix;
    logic [15:0] v;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic fin_req = 1'b0;
  logic mon_done = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [15:0] sample(sig_e s);
    case (s)
      S_XB:    return {14'd0, x_bank};
      S_YB:    return {14'd0, y_bank};
      S_ZB:    return {14'd0, z_bank};
      S_BUSY:  return {15'd0, busy};
      S_DONE:  return {15'd0, done};
      S_ERR:   return {15'd0, error};
      S_CMDR:  return {15'd0, bus.cmd_ready};
      S_COEFR: return {15'd0, bus.coef_ready};
      S_UEN:   return {15'd0, update_en};
      S_UAX:   return {14'd0, update_axis};
      S_UBK:   return {14'd0, update_bank};
      S_UIDX:  return {12'd0, update_index};
      S_UVAL:  return update_value;
      default: return 16'hdead;
    endcase
  endfunction

  // Monitor: scheduled signal checks and write scoreboard.
  always @(negedge sys_clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        checks++;
        if (exp_q[i].cyc < cyc) begin
          failures++;
          $display("FAIL %s stale check for cyc %0d",
                   exp_q[i].sig.name(), exp_q[i].cyc);
        end else if (sample(exp_q[i].sig)
                     !== exp_q[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h",
                   exp_q[i].sig.name(), cyc,
                   sample(exp_q[i].sig), exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
    while (wq.size() > 0 && wq[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL write_missing idx=%0d cyc=%0d",
               wq[0].ix, wq[0].cyc);
      void'(wq.pop_front());
    end
    if (update_en === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected cyc=%0d idx=%0d",
                 cyc, update_index);
      end else begin
        wr_t w;
        w = wq.pop_front();
        if (w.cyc != cyc || update_axis !== w.ax ||
            update_bank !== w.bk ||
            update_index !== w.ix ||
            update_value !== w.v) begin
          failures++;
          $display({"FAIL write cyc/ax/bk/ix/v ",
                    "got=%0d/%0d/%0d/%0d/%0h ",
                    "want=%0d/%0d/%0d/%0d/%0h"},
                   cyc, update_axis, update_bank,
                   update_index, update_value,
                   w.cyc, w.ax, w.bk, w.ix, w.v);
        end
      end
    end
    if (fin_req && !mon_done) begin
      checks++;
      if (exp_q.size() != 0 || wq.size() != 0) begin
        failures++;
        $display("FAIL leftover got=%0d/%0d want=0/0",
                 exp_q.size(), wq.size());
      end
      mon_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_at(input int c, input sig_e s,
                           input logic [15:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_reset(input int c);
    expect_at(c, S_XB, 0);
    expect_at(c, S_YB, 0);
    expect_at(c, S_ZB, 0);
    expect_at(c, S_BUSY, 0);
    expect_at(c, S_DONE, 0);
    expect_at(c, S_ERR, 0);
    expect_at(c, S_CMDR, 1);
    expect_at(c, S_COEFR, 0);
    expect_at(c, S_UEN, 0);
    expect_at(c, S_UAX, 0);
    expect_at(c, S_UBK, 0);
    expect_at(c, S_UIDX, 0);
    expect_at(c, S_UVAL, 0);
  endtask

  task automatic send_cmd(input logic [1:0] ax,
                          input logic [1:0] bk,
                          input logic act,
                          output int acc);
    bus.cmd_valid    = 1'b1;
    bus.cmd_axis     = ax;
    bus.cmd_bank     = bk;
    bus.cmd_activate = act;
    for (int t = 0; t < 100; t++) begin
      @(negedge sys_clk);
      if (bus.cmd_ready) begin
        acc = cyc;
        tick();
        bus.cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    $display("FAIL cmd_handshake got=stuck want=ready");
    $fatal(1, "cmd handshake never completed");
  endtask

  task automatic send_beat(input logic [15:0] v,
                           input logic [1:0] ax,
                           input logic [1:0] bk,
                           input logic [3:0] ix,
                           output int acc);
    wr_t w;
    bus.coef_valid = 1'b1;
    bus.coef_data  = v;
    for (int t = 0; t < 100; t++) begin
      @(negedge sys_clk);
      if (bus.coef_ready) begin
        acc  = cyc;
        w.cyc = cyc + 1;
        w.ax = ax;
        w.bk = bk;
        w.ix = ix;
        w.v  = v;
        wq.push_back(w);
        tick();
        bus.coef_valid = 1'b0;
        return;
      end
      tick();
    end
    $display("FAIL coef_handshake got=stuck want=ready");
    $fatal(1, "coef handshake never completed");
  endtask

  initial begin
    int a, b, last, r;
    rst_n            = 1'b0;
    path_available   = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_axis     = 2'd0;
    bus.cmd_bank     = 2'd0;
    bus.cmd_activate = 1'b0;
    bus.coef_valid   = 1'b0;
    bus.coef_data    = 16'd0;
    tick();
    expect_reset(cyc);
    tick();
    rst_n = 1'b1;
    tick();

    // x -> bank1, back-to-back, activate
    send_cmd(2'd1, 2'd1, 1'b1, a);
    expect_at(a + 1, S_BUSY, 1);
    expect_at(a + 1, S_CMDR, 0);
    expect_at(a + 1, S_COEFR, 1);
    for (int i = 0; i < 16; i++)
      send_beat(16'h0100 + 16'(i), 2'd1, 2'd1,
                4'(i), last);
    expect_at(last + 2, S_XB, 0);
    expect_at(last + 2, S_DONE, 0);
    expect_at(last + 3, S_XB, 1);
    expect_at(last + 3, S_DONE, 1);
    expect_at(last + 3, S_YB, 0);
    expect_at(last + 3, S_ZB, 0);
    expect_at(last + 4, S_DONE, 0);
    expect_at(last + 4, S_BUSY, 0);
    expect_at(last + 4, S_CMDR, 1);
    repeat (6) tick();

    // z -> bank2, path busy for 100 cycles
    path_available = 1'b0;
    send_cmd(2'd3, 2'd2, 1'b1, a);
    for (int i = 0; i < 16; i++)
      send_beat(16'ha000 + 16'(3 * i), 2'd3, 2'd2,
                4'(i), last);
    for (int k = 1; k <= 100; k++) begin
      expect_at(last + k, S_ZB, 0);
      expect_at(last + k, S_BUSY, 1);
    end
    repeat (100) tick();
    r = cyc;
    path_available = 1'b1;
    expect_at(r + 1, S_ZB, 0);
    expect_at(r + 2, S_ZB, 2);
    expect_at(r + 2, S_DONE, 1);
    repeat (4) tick();

    // rejects: live bank, axis 0, live nonzero bank
    send_cmd(2'd2, 2'd0, 1'b1, a);
    expect_at(a + 1, S_ERR, 1);
    expect_at(a + 1, S_UEN, 0);
    expect_at(a + 1, S_BUSY, 0);
    expect_at(a + 1, S_CMDR, 1);
    expect_at(a + 1, S_DONE, 0);
    expect_at(a + 2, S_ERR, 0);
    expect_at(a + 2, S_YB, 0);
    repeat (2) tick();
    send_cmd(2'd0, 2'd1, 1'b1, a);
    expect_at(a + 1, S_ERR, 1);
    expect_at(a + 1, S_BUSY, 0);
    expect_at(a + 2, S_ERR, 0);
    expect_at(a + 2, S_UEN, 0);
    repeat (2) tick();
    send_cmd(2'd1, 2'd1, 1'b0, a);
    expect_at(a + 1, S_ERR, 1);
    expect_at(a + 1, S_BUSY, 0);
    expect_at(a + 2, S_XB, 1);
    repeat (2) tick();

    // timeout after 5 beats into y bank3
    send_cmd(2'd2, 2'd3, 1'b1, a);
    for (int i = 0; i < 5; i++)
      send_beat(16'h0300 + 16'(i), 2'd2, 2'd3,
                4'(i), b);
    expect_at(b + 2, S_UEN, 0);
    expect_at(b + 19, S_ERR, 0);
    expect_at(b + 19, S_BUSY, 1);
    expect_at(b + 19, S_COEFR, 1);
    expect_at(b + 20, S_ERR, 1);
    expect_at(b + 20, S_BUSY, 0);
    expect_at(b + 20, S_CMDR, 1);
    expect_at(b + 20, S_COEFR, 0);
    expect_at(b + 20, S_UEN, 0);
    expect_at(b + 20, S_DONE, 0);
    expect_at(b + 21, S_ERR, 0);
    expect_at(b + 21, S_YB, 0);
    repeat (21) tick();

    // x bank3, no activate, beats every 3rd cycle
    send_cmd(2'd1, 2'd3, 1'b0, a);
    expect_at(a + 1, S_BUSY, 1);
    for (int i = 0; i < 16; i++) begin
      send_beat(16'h7f00 ^ 16'(i * 17), 2'd1, 2'd3,
                4'(i), last);
      if (i < 15) begin
        tick();
        tick();
      end
    end
    expect_at(last + 1, S_DONE, 1);
    expect_at(last + 2, S_DONE, 0);
    expect_at(last + 2, S_XB, 1);
    expect_at(last + 2, S_BUSY, 0);
    repeat (3) tick();

    // reset in the middle of a y bank1 load
    send_cmd(2'd2, 2'd1, 1'b1, a);
    for (int i = 0; i < 8; i++)
      send_beat(16'h0400 + 16'(i), 2'd2, 2'd1,
                4'(i), b);
    tick();
    rst_n = 1'b0;
    expect_reset(cyc);
    tick();
    rst_n = 1'b1;
    tick();
    send_cmd(2'd2, 2'd1, 1'b1, a);
    for (int i = 0; i < 16; i++)
      send_beat(16'h0500 + 16'(i), 2'd2, 2'd1,
                4'(i), last);
    expect_at(last + 2, S_YB, 0);
    expect_at(last + 3, S_YB, 1);
    expect_at(last + 3, S_DONE, 1);
    expect_at(last + 3, S_XB, 0);
    repeat (5) tick();

    fin_req = 1'b1;
    repeat (2) @(posedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
